// File: rtl/dram_march_tester.sv
// March C- built-in self-test master for the DRAM controller host bus.
// Optional MARCH_TESTER_ADDR_PATTERN_EN folds addr[7:0]^addr[15:8] into every data byte.
module dram_march_tester #(
  parameter logic [15:0] ADDR_LAST  = 16'hFFFF,
  parameter logic [7:0]  CONF_VALUE = 8'h00,
  parameter logic [7:0]  DATA_BG    = 8'h00,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [15:0] err_addr,
  output logic [7:0]  err_exp,
  output logic [7:0]  err_act,
  output logic [15:0] addr,
  output logic        CSn,
  output logic        RWn,
  output logic        CONFn,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        RDY
);

`ifdef MARCH_TESTER_ADDR_PATTERN_EN
  localparam logic ADDR_PAT = 1'b1;
`else
  localparam logic ADDR_PAT = 1'b0;
`endif

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] ELEM_LAST = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_ACC,
    S_GAP,
    S_TOUT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  logic        phase_q, phase_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tout_q, tout_d;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] err_addr_q, err_addr_d;
  logic [7:0]  err_exp_q, err_exp_d;
  logic [7:0]  err_act_q, err_act_d;
  logic [15:0] addr_q, addr_d;
  logic        csn_q, csn_d;
  logic        rwn_q, rwn_d;
  logic        confn_q, confn_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rd_exp;

  // Elements 3 and 4 walk the address range downward.
  function automatic logic elem_up(input logic [2:0] e);
    return !((e == 3'd3) || (e == 3'd4));
  endfunction

  // Element 0 is write-only, element 5 read-only, the others read (phase 0) then write.
  function automatic logic acc_is_read(input logic [2:0] e, input logic p);
    return (e == ELEM_LAST) || ((e != 3'd0) && !p);
  endfunction

  function automatic logic acc_compl(input logic [2:0] e, input logic p);
    if (acc_is_read(e, p))
      return (e == 3'd2) || (e == 3'd4);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  function automatic logic [7:0] pattern(input logic compl, input logic [15:0] a);
    logic [7:0] base;
    base = compl ? ~DATA_BG : DATA_BG;
    return ADDR_PAT ? (base ^ a[7:0] ^ a[15:8]) : base;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    tcnt_d      = tcnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    tout_d      = tout_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    err_exp_d   = err_exp_q;
    err_act_d   = err_act_q;
    addr_d      = addr_q;
    csn_d       = csn_q;
    rwn_d       = rwn_q;
    confn_d     = confn_q;
    wdata_d     = wdata_q;
    rd_exp      = pattern(acc_compl(elem_q, phase_q), addr_q);

    case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) begin
          state_d     = S_CONF;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          tout_d      = 1'b0;
          err_count_d = 16'd0;
          err_addr_d  = 16'd0;
          err_exp_d   = 8'd0;
          err_act_d   = 8'd0;
          csn_d       = 1'b0;
          confn_d     = 1'b0;
          rwn_d       = 1'b0;
          wdata_d     = CONF_VALUE;
          addr_d      = 16'd0;
          elem_d      = 3'd0;
          phase_d     = 1'b0;
          tcnt_d      = 8'd0;
        end
      end

      S_CONF, S_ACC: begin
        if (RDY) begin
          csn_d   = 1'b1;
          confn_d = 1'b1;
          state_d = S_GAP;
          if (state_q == S_ACC) begin
            if (rwn_q && (rdata != rd_exp)) begin
              err_count_d = sat_inc(err_count_q);
              if (err_count_q == 16'd0) begin
                err_addr_d = addr_q;
                err_exp_d  = rd_exp;
                err_act_d  = rdata;
              end
            end
            if ((elem_q == ELEM_LAST) && (addr_q == ADDR_LAST)) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_count_d == 16'd0);
            end else if ((elem_q != 3'd0) && (elem_q != ELEM_LAST) && !phase_q) begin
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              // Address wraps only when an element has covered its whole range.
              if (addr_q == (elem_up(elem_q) ? ADDR_LAST : 16'd0)) begin
                elem_d = elem_q + 3'd1;
                addr_d = elem_up(elem_q + 3'd1) ? 16'd0 : ADDR_LAST;
              end else begin
                addr_d = elem_up(elem_q) ? addr_q + 16'd1 : addr_q - 16'd1;
              end
            end
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d = S_TOUT;
          csn_d   = 1'b1;
          confn_d = 1'b1;
          tout_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      S_GAP: begin
        state_d = S_ACC;
        csn_d   = 1'b0;
        tcnt_d  = 8'd0;
        rwn_d   = acc_is_read(elem_q, phase_q);
        if (!rwn_d)
          wdata_d = pattern(acc_compl(elem_q, phase_q), addr_q);
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      phase_q     <= 1'b0;
      tcnt_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tout_q      <= 1'b0;
      err_count_q <= 16'd0;
      err_addr_q  <= 16'd0;
      err_exp_q   <= 8'd0;
      err_act_q   <= 8'd0;
      addr_q      <= 16'd0;
      csn_q       <= 1'b1;
      rwn_q       <= 1'b1;
      confn_q     <= 1'b1;
      wdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      tcnt_q      <= tcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tout_q      <= tout_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      err_exp_q   <= err_exp_d;
      err_act_q   <= err_act_d;
      addr_q      <= addr_d;
      csn_q       <= csn_d;
      rwn_q       <= rwn_d;
      confn_q     <= confn_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = tout_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign err_exp   = err_exp_q;
  assign err_act   = err_act_q;
  assign addr      = addr_q;
  assign CSn       = csn_q;
  assign RWn       = rwn_q;
  assign CONFn     = confn_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_dram_march_tester.sv
// Bench for dram_march_tester: randomized-latency controller model with fault injection
// and a March C- expected-access list built from the element table.
`timescale 1ns/1ps
module tb_dram_march_tester;

`ifdef MARCH_TESTER_ADDR_PATTERN_EN
  localparam logic [15:0] AL = 16'h01FF;
  localparam int LAT_MAX = 1;
  localparam bit PAT_EN = 1'b1;
`else
  localparam logic [15:0] AL = 16'h000F;
  localparam int LAT_MAX = 5;
  localparam bit PAT_EN = 1'b0;
`endif
  localparam logic [7:0] BG   = 8'h00;
  localparam logic [7:0] CONF = 8'h00;
  localparam int TO     = 255;
  localparam int TOTAL  = 1 + 10 * (int'(AL) + 1);
  localparam int M3S    = 1 + 5 * (int'(AL) + 1);
  localparam int BUDGET = TOTAL * (LAT_MAX + 3) + 2000;

  logic        clk, RESET, start;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count, err_addr, addr;
  logic [7:0]  err_exp, err_act, wdata;
  logic        CSn, RWn, CONFn;
  logic [7:0]  rdata = 8'h00;
  logic        RDY = 1'b0;

  dram_march_tester #(
    .ADDR_LAST(AL), .CONF_VALUE(CONF), .DATA_BG(BG), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .RESET(RESET), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .err_addr(err_addr), .err_exp(err_exp),
    .err_act(err_act), .addr(addr), .CSn(CSn), .RWn(RWn), .CONFn(CONFn),
    .wdata(wdata), .rdata(rdata), .RDY(RDY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
  endtask

  // Fault controls, written only by the stimulus process.
  logic        stuck_en = 1'b0;
  logic [15:0] f_addr   = 16'h0;
  logic [7:0]  f_mask   = 8'h0;
  logic        no_rdy   = 1'b0;
  logic        alias_en = 1'b0;
  int          run_id   = 0;

  // Expected access list: address, RWn, data.
  logic [15:0] qa[$];
  logic        qr[$];
  logic [7:0]  qd[$];

  function automatic logic [7:0] pat(input bit cp, input logic [15:0] a);
    logic [7:0] v;
    v = cp ? ~BG : BG;
    return PAT_EN ? (v ^ a[7:0] ^ a[15:8]) : v;
  endfunction

  task automatic build_expected();
    string ops [6];
    bit    up [6];
    string s;
    logic [15:0] a;
    ops = '{"wB", "rBwC", "rCwB", "rBwC", "rCwB", "rB"};
    up  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    qa.delete(); qr.delete(); qd.delete();
    qa.push_back(16'h0000); qr.push_back(1'b0); qd.push_back(CONF);
    for (int e = 0; e < 6; e++) begin
      s = ops[e];
      for (int k = 0; k <= int'(AL); k++) begin
        a = up[e] ? 16'(k) : 16'(int'(AL) - k);
        for (int o = 0; o < s.len() / 2; o++) begin
          qa.push_back(a);
          qr.push_back(s[2*o] == "r");
          qd.push_back(pat(s[2*o+1] == "C", a));
        end
      end
    end
  endtask

  function automatic int midx(input logic [15:0] a);
    if (alias_en && a == 16'h0100) return 0;
    return int'(a[8:0]);
  endfunction

  // Controller model and protocol monitor state, written only by the model process.
  logic [7:0]  mem [0:511];
  int          last_run = 0;
  int          acc_idx = 0, low_len = 0, gap_len = 0;
  int          stab_err = 0, gap_err = 0, fld_err = 0, first_bad = -1;
  int          m_errs = 0;
  logic [15:0] m_faddr = 16'h0;
  logic [7:0]  m_fexp = 8'h0, m_fact = 8'h0;
  logic        prev_csn = 1'b1;
  logic [15:0] s_addr = 16'h0;
  logic        s_rwn = 1'b1, s_confn = 1'b1;
  logic [7:0]  s_wdata = 8'h0;
  int          wcnt = 0, lat = 1;
  bit          acc_done = 1'b0;

  always @(negedge clk) begin : model
    int cur;
    logic [7:0] v;
    if (run_id != last_run) begin
      last_run = run_id; acc_idx = 0; low_len = 0; stab_err = 0; gap_err = 0;
      fld_err = 0; first_bad = -1; m_errs = 0; m_faddr = 0; m_fexp = 0; m_fact = 0;
    end
    if (!CSn && prev_csn) begin
      if (acc_idx > 0 && gap_len != 1) gap_err++;
      if (acc_idx >= qa.size() || addr !== qa[acc_idx] || RWn !== qr[acc_idx] ||
          CONFn !== (acc_idx != 0) || (!RWn && wdata !== qd[acc_idx])) begin
        fld_err++;
        if (first_bad < 0) first_bad = acc_idx;
      end
      s_addr = addr; s_rwn = RWn; s_confn = CONFn; s_wdata = wdata;
      acc_idx++; low_len = 0; wcnt = 0; acc_done = 1'b0;
      lat = int'($urandom_range(LAT_MAX, 1));
    end
    if (!CSn) begin
      low_len++;
      if (addr !== s_addr || RWn !== s_rwn || CONFn !== s_confn || wdata !== s_wdata)
        stab_err++;
      if (!acc_done) begin
        wcnt++;
        if (!no_rdy && wcnt >= lat) begin
          RDY = 1'b1;
          acc_done = 1'b1;
          if (CONFn && RWn) begin
            v = mem[midx(addr)];
            if (stuck_en && addr == f_addr) v = v | f_mask;
            rdata = v;
            cur = acc_idx - 1;
            if (cur < qd.size() && v !== qd[cur]) begin
              if (m_errs == 0) begin m_faddr = addr; m_fexp = qd[cur]; m_fact = v; end
              m_errs++;
            end
          end else if (CONFn) begin
            mem[midx(addr)] = wdata;
          end
        end else begin
          RDY = 1'b0;
        end
      end
    end else begin
      gap_len = prev_csn ? gap_len + 1 : 1;
      acc_done = 1'b0;
      RDY = ($urandom_range(3, 0) == 0);
      rdata = 8'($urandom);
    end
    prev_csn = CSn;
  end

  task automatic begin_run(input string nm);
    build_expected();
    run_id++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({nm, ":busy_on_start"}, busy, 1'b1);
    check({nm, ":status_cleared"}, {done, pass, timeout}, 3'b000);
    check({nm, ":err_cleared"}, err_count, 16'h0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check({nm, ":done_reached"}, done, 1'b1);
  endtask

  task automatic run_march(input string nm, input bit poke, input bit req_pass);
    begin_run(nm);
    if (poke) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(nm, BUDGET);
    check({nm, ":busy"}, busy, 1'b0);
    check({nm, ":timeout"}, timeout, 1'b0);
    check({nm, ":csn_idle"}, CSn, 1'b1);
    check({nm, ":accesses"}, acc_idx, TOTAL);
    check({nm, ":access_fields"}, fld_err, 0);
    if (fld_err != 0) $display("  first bad access index %0d", first_bad);
    check({nm, ":stable_while_selected"}, stab_err, 0);
    check({nm, ":one_cycle_gap"}, gap_err, 0);
    check({nm, ":err_count"}, err_count, m_errs);
    check({nm, ":pass_model"}, pass, (m_errs == 0));
    check({nm, ":pass_required"}, pass, req_pass);
    if (m_errs > 0) begin
      check({nm, ":err_addr"}, err_addr, m_faddr);
      check({nm, ":err_exp"}, err_exp, m_fexp);
      check({nm, ":err_act"}, err_act, m_fact);
    end
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:CSn", CSn, 1'b1);
    check("rst:CONFn", CONFn, 1'b1);
    check("rst:RWn", RWn, 1'b1);
    check("rst:addr", addr, 16'h0);
    check("rst:wdata", wdata, 8'h0);
    check("rst:status", {busy, done, pass, timeout}, 4'b0000);
    check("rst:err_count", err_count, 16'h0);
    check("rst:err_detail", {err_addr, err_exp, err_act}, 32'h0);
    RESET = 1'b0;

    run_march("clean", 1'b1, 1'b1);

    stuck_en = 1'b1; f_addr = 16'h0007; f_mask = 8'h04;
    run_march("stuck7", 1'b0, 1'b0);
`ifndef MARCH_TESTER_ADDR_PATTERN_EN
    check("stuck7:count3", err_count, 16'd3);
    check("stuck7:addr7", err_addr, 16'h0007);
    check("stuck7:exp00", err_exp, 8'h00);
    check("stuck7:act04", err_act, 8'h04);
`endif

    f_addr = 16'($urandom_range(int'(AL), 0));
    f_mask = 8'(1 << $urandom_range(7, 0));
    run_march("rnd_stuck", 1'b0, 1'b0);
    check("rnd_stuck:seen", (err_count != 16'h0), 1'b1);
    stuck_en = 1'b0;

    no_rdy = 1'b1;
    begin_run("tout");
    wait_done("tout", TO + 50);
    check("tout:timeout", timeout, 1'b1);
    check("tout:pass", pass, 1'b0);
    check("tout:busy", busy, 1'b0);
    check("tout:csn", CSn, 1'b1);
    check("tout:accesses", acc_idx, 1);
    check("tout:low_cycles", low_len, TO);
    no_rdy = 1'b0;

    stuck_en = 1'b1; f_addr = 16'h0003; f_mask = 8'h80;
    begin_run("midrst");
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk); #1;
      if (acc_idx >= M3S + 5 && !CSn) break;
    end
    check("midrst:reached_m3", (acc_idx >= M3S + 5), 1'b1);
    check("midrst:m3_descending_addr", addr, 16'(int'(AL) - (acc_idx - 1 - M3S) / 2));
    check("midrst:err_before", (err_count != 16'h0), 1'b1);
    RESET = 1'b1;
    @(posedge clk); #1;
    check("midrst:csn", CSn, 1'b1);
    check("midrst:busy", busy, 1'b0);
    check("midrst:err_count", err_count, 16'h0);
    check("midrst:status", {done, pass, timeout}, 3'b000);
    RESET = 1'b0;
    stuck_en = 1'b0;
    run_march("after_rst", 1'b0, 1'b1);

`ifdef MARCH_TESTER_ADDR_PATTERN_EN
    alias_en = 1'b1;
    run_march("alias", 1'b0, 1'b0);
    check("alias:errs", (err_count != 16'h0), 1'b1);
    check("alias:err_addr0", err_addr, 16'h0000);
    alias_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_march_tester.md
Name: dram_march_tester

Overview:
- Built-in self-test master that sits directly upstream of the DRAM controller and drives its host bus: addr, CSn, RWn, CONFn, with handshake on RDY.
- Writes the controller configuration once, then runs a March C- sequence over a programmable address range.
- Compares every read against the expected pattern and reports pass/fail, error count and first-failure details.
- Exposed on the chip-level bidir pads or to an on-chip monitor for silicon bring-up of the external DRAM.

Parameters:
- ADDR_LAST, 16'hFFFF, highest address tested; the range is 0..ADDR_LAST inclusive.
- CONF_VALUE, 8'h00, byte driven on wdata during the configuration cycle.
- DATA_BG, 8'h00, background pattern; the complement is ~DATA_BG.
- TIMEOUT, 255, maximum cycles to wait for RDY per access (8-bit counter).

Ports:
- clk  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE, DONE or TOUT
- busy  out  1  high from start acceptance until DONE/TOUT
- done  out  1  high in DONE or TOUT, held until next start
- pass  out  1  valid when done: 1 when err_count==0 and no timeout
- timeout  out  1  RDY not seen within TIMEOUT cycles
- err_count  out  16  mismatching reads, saturates at 16'hFFFF
- err_addr  out  16  address of first mismatch
- err_exp  out  8  expected byte of first mismatch
- err_act  out  8  actual byte of first mismatch
- addr  out  16  host address to controller
- CSn  out  1  chip select, active low
- RWn  out  1  1=read, 0=write
- CONFn  out  1  low during the configuration cycle only
- wdata  out  8  write data toward the controller's write latch
- rdata  in  8  read data from the controller's read latch
- RDY  in  1  controller access-complete strobe

Behaviour:
- Reset values:
  - CSn=1, CONFn=1, RWn=1, addr=0, wdata=0
  - busy=0, done=0, pass=0, timeout=0
  - err_count=0, err_addr=0, err_exp=0, err_act=0
  - state=IDLE
- States: IDLE, CONF, ACC, GAP, TOUT, DONE.
- start accepted:
  - Clears all error/status outputs.
  - Sets busy=1 and goes to CONF. Next cycle drives CSn=0, CONFn=0, RWn=0, wdata=CONF_VALUE, addr=0.
  - start while busy is ignored.
- Access handshake (CONF and ACC):
  - Outputs are registered and held stable while CSn=0.
  - RDY is sampled every cycle. The cycle RDY==1 is seen completes the access; for reads, rdata is captured in that cycle.
  - Next cycle: GAP, with CSn=1, CONFn=1, for exactly one cycle before the next access.
  - RDY high while CSn=1 is ignored.
- March elements, executed in order. Bg=DATA_BG, Cp=~DATA_BG. Each element visits every address; "r x" = read expecting x, "w x" = write x.
  - M0: up, w Bg
  - M1: up, r Bg then w Cp
  - M2: up, r Cp then w Bg
  - M3: down, r Bg then w Cp
  - M4: down, r Cp then w Bg
  - M5: up, r Bg
  - "up" means 0..ADDR_LAST; "down" means ADDR_LAST..0.
  - In a read-then-write pair, the read and the write are separate accesses to the same address, separated by GAP.
  - The address counter wraps only at element boundaries. ADDR_LAST=0 yields one address per element.
  - Total accesses = 1 + 10*(ADDR_LAST+1).
- Compare on read completion:
  - On mismatch, err_count increments (saturating at 16'hFFFF).
  - If this is the first mismatch (err_count was 0), also latch err_addr, err_exp and err_act.
  - A mismatch does not stop the test.
- Timeout:
  - Per-access counter is cleared when CSn falls and increments each cycle CSn=0 and RDY=0.
  - Reaching TIMEOUT → TOUT: CSn=1, timeout=1, busy=0, done=1, pass=0.
- DONE: entered after the last M5 read completes. Sets busy=0, done=1, pass=(err_count==0).
- RESET mid-test: CSn releases to 1 on the next edge; all state returns to reset values.

Optional Feature:
- Macro: MARCH_TESTER_ADDR_PATTERN_EN.
- Defined:
  - Expected and write data become Bg^addr[7:0]^addr[15:8] or Cp^addr[7:0]^addr[15:8].
  - This detects address-line aliasing.
- Undefined: data is exactly Bg or Cp.
- Configuration cycle unaffected in both cases.

Test Plan:
- Controller model, zero-defect 256-byte memory, RDY after 3 cycles; ADDR_LAST=15, start pulse:
  - Exactly 161 accesses, first with CONFn=0 and wdata=8'h00.
  - Then done=1, pass=1, err_count=0.
- Model with bit 2 of address 16'h0007 stuck at 1:
  - Read in M1 returns 8'h04 → err_addr=16'h0007, err_exp=8'h00, err_act=8'h04.
  - Final err_count=3 (M1, M3, M5 reads); pass=0.
- Model never asserts RDY:
  - CSn held 0 for 255 cycles, then CSn=1, timeout=1, done=1, pass=0.
- RESET asserted during M3:
  - Next edge CSn=1, busy=0, err_count=0.
  - A new start runs a full clean test to pass=1.
- Protocol checks across all accesses:
  - addr, RWn and wdata stable while CSn=0.
  - Exactly one CSn=1 cycle between accesses.
  - M3 addresses descend 15..0.
- With MARCH_TESTER_ADDR_PATTERN_EN and model aliasing addr 16'h0100 onto 16'h0000 (ADDR_LAST=16'h01FF): pass=0, err_count>0, err_addr=16'h0000.
